// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: bundle between EX decode, the multiplier, the divider,
// the HI/LO register file and the muldiv sequencer.
//   master : EX / units side (drives op request, unit results)
//   slave  : muldiv_ctrl (drives unit operands, stallreq, HI/LO writes)
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        annul;
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  modport master (
    output op_valid, op_type, src1, src2, annul, mul_result, div_result, div_ready,
    input  mul_signed, mul_ina, mul_inb, div_start, div_signed, div_op1, div_op2,
           div_annul, stallreq, hi_we, lo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  op_valid, op_type, src1, src2, annul, mul_result, div_result, div_ready,
    output mul_signed, mul_ina, mul_inb, div_start, div_signed, div_op1, div_op2,
           div_annul, stallreq, hi_we, lo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for the multiplier and iterative divider.
// Accepts MULT/MULTU/DIV/DIVU, holds operands, drives the unit, stalls the
// pipe until the result is in, then pulses HI/LO writes for one cycle.
// MTHI/MTLO are written straight through in a single cycle.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       muldiv_ctrl_if.slave (op request, unit handshake, HI/LO writes)
// Param:
//   MUL_LAT   multiplier latency in cycles, 1..7
module muldiv_ctrl #(
  parameter int MUL_LAT = 1
) (
  input logic         clk,
  input logic         rst,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        sgn_r;
  logic [31:0] a_r, b_r;
  logic [63:0] res_r;

  // live: nothing is being flushed or reset this cycle; every output that
  // causes an effect is gated by it so a flush/reset never leaks a write.
  logic live, accept, mt_hi, mt_lo, in_mul, in_div, done;

  assign live   = !rst && !bus.annul;
  assign accept = live && state == IDLE && bus.op_valid && !bus.op_type[2];
  assign mt_hi  = live && state == IDLE && bus.op_valid && bus.op_type == 3'd4;
  assign mt_lo  = live && state == IDLE && bus.op_valid && bus.op_type == 3'd5;
  assign in_mul = live && state == MUL_WAIT;
  assign in_div = live && state == DIV_WAIT;
  assign done   = live && state == DONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sgn_r <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
    end else if (bus.annul) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sgn_r <= !bus.op_type[0];
          a_r   <= bus.src1;
          b_r   <= bus.src2;
          if (!bus.op_type[1]) begin
            state <= MUL_WAIT;
            cnt   <= 3'(MUL_LAT);
          end else if (bus.src2 == '0) begin
            // divide by zero: skip the divider, fixed result
            state <= DONE;
            res_r <= {bus.src1, 32'hFFFF_FFFF};
          end else begin
            state <= DIV_WAIT;
          end
        end
        MUL_WAIT: if (cnt == 3'd1) begin
          res_r <= bus.mul_result;
          cnt   <= '0;
          state <= DONE;
        end else begin
          cnt <= cnt - 3'd1;
        end
        DIV_WAIT: if (bus.div_ready) begin
          res_r <= bus.div_result;
          state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  assign bus.stallreq   = accept || in_mul || in_div;

  assign bus.mul_signed = in_mul && sgn_r;
  assign bus.mul_ina    = in_mul ? a_r : '0;
  assign bus.mul_inb    = in_mul ? b_r : '0;

  // start held until the divider reports ready, dropped in the ready cycle
  assign bus.div_start  = in_div && !bus.div_ready;
  assign bus.div_signed = in_div && sgn_r;
  assign bus.div_op1    = in_div ? a_r : '0;
  assign bus.div_op2    = in_div ? b_r : '0;
  assign bus.div_annul  = !rst && bus.annul && state == DIV_WAIT;

  assign bus.hi_we    = done || mt_hi;
  assign bus.lo_we    = done || mt_lo;
  assign bus.hi_wdata = done ? res_r[63:32] : (mt_hi ? bus.src1 : '0);
  assign bus.lo_wdata = done ? res_r[31:0]  : (mt_lo ? bus.src1 : '0);

endmodule
